sdff_scan_bank: RTL



---
 rtl/sdff_scan_pkg.sv | 22 ++
 rtl/sdff_scan_ctrl.sv | 51 +++++
 rtl/sdff_scan_bank.sv | 63 ++++++
 3 files changed

// File: rtl/sdff_scan_pkg.sv
// Shared types and sizing helpers for the scan register bank and its controller.
package sdff_scan_pkg;

  localparam int MAX_WIDTH = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } scan_state_e;

  // Counter width for a chain of the given length, never narrower than one bit.
  function automatic int cnt_w(input int width);
    int w;
    w = $clog2(width);
    if (w > 1) begin
      return w;
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/sdff_scan_ctrl.sv
// Scan controller: IDLE/SHIFT FSM, shift counter and the chain-complete pulse.
module sdff_scan_ctrl
  import sdff_scan_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic setn,
  input  logic se,
  output logic scan_active,
  output logic shift_done
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  scan_state_e      state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             done_r;
  logic             shift_s;

  // A shift edge is exactly the case where the bank takes its SE branch.
  assign shift_s = setn & se;

  // FSM, counter and done pulse; any non-shifting edge abandons a partial chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      done_r  <= 1'b0;
    end else if (shift_s) begin
      state_r <= SHIFT;
      if (cnt_r == CNT_LAST) begin
        cnt_r  <= {CNT_W{1'b0}};
        done_r <= 1'b1;
      end else begin
        cnt_r  <= cnt_r + CNT_W'(1);
        done_r <= 1'b0;
      end
    end else begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      done_r  <= 1'b0;
    end
  end

  assign scan_active = (state_r == SHIFT);
  assign shift_done  = done_r;

endmodule

// File: rtl/sdff_scan_bank.sv
// WIDTH-bit muxed-scan register bank with load enable, synchronous preset and
// a shift-complete indication for the test controller.
module sdff_scan_bank
  import sdff_scan_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] SET_VAL   = {WIDTH{1'b1}}
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SETN,
  input  logic             SE,
  input  logic             SI,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             SO,
  output logic             SCAN_ACTIVE,
  output logic             SHIFT_DONE
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next_s;

  // Bank next-state priority below reset: preset, then shift, then load, else hold.
  always_comb begin
    q_next_s = q_r;
    if (!SETN) begin
      q_next_s = SET_VAL;
    end else if (SE) begin
      q_next_s = {q_r[WIDTH-2:0], SI};
    end else if (EN) begin
      q_next_s = D;
    end else begin
      q_next_s = q_r;
    end
  end

  // Bank storage with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q_r <= RESET_VAL;
    end else begin
      q_r <= q_next_s;
    end
  end

  assign Q  = q_r;
  assign SO = q_r[WIDTH-1];

  sdff_scan_ctrl #(
    .WIDTH(WIDTH)
  ) u_ctrl (
    .clk        (CLK),
    .rst        (RST),
    .setn       (SETN),
    .se         (SE),
    .scan_active(SCAN_ACTIVE),
    .shift_done (SHIFT_DONE)
  );

endmodule
